// File: rtl/regfile_wb_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_pipe_pkg
// Description : Shared select codes and default syscall read addresses for the
//               register-file write-back pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_pipe_pkg;

    // Write-data source codes; 2'b10 falls back to memory data.
    localparam logic [1:0] WSRC_MEM  = 2'b00;
    localparam logic [1:0] WSRC_ALU  = 2'b01;
    localparam logic [1:0] WSRC_PC   = 2'b11;

    // Destination select codes; any code with bit 1 set selects the link register.
    localparam logic [1:0] WDST_P2   = 2'b00;
    localparam logic [1:0] WDST_P4   = 2'b01;
    localparam logic [1:0] WDST_LINK = 2'b10;

    localparam int unsigned SYS_RA_DEFAULT = 2;
    localparam int unsigned SYS_RB_DEFAULT = 4;

endpackage : regfile_wb_pipe_pkg
`default_nettype wire

// File: rtl/regfile_wb_pipe_array.sv
`default_nettype none
// ============================================================================
// Module      : regfile_array
// Description : 2-read / 1-write register storage with synchronous clear and
//               optional hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
import regfile_wb_pipe_pkg::*;

module regfile_array #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    localparam int unsigned C_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem_q [C_DEPTH];
    logic [DATA_W-1:0] w_mem_d [C_DEPTH];
    logic              w_wr_en;

    assign w_wr_en = i_we && !((ZERO_REG != 0) && (i_waddr == '0));

    always_comb begin
        w_mem_d = r_mem_q;
        if (w_wr_en) begin
            w_mem_d[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(C_DEPTH); i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    assign o_rdata_a = ((ZERO_REG != 0) && (i_raddr_a == '0)) ? '0 : r_mem_q[i_raddr_a];
    assign o_rdata_b = ((ZERO_REG != 0) && (i_raddr_b == '0)) ? '0 : r_mem_q[i_raddr_b];

endmodule : regfile_array
`default_nettype wire

// File: rtl/regfile_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_pipe
// Description : Register file with write-back source/destination muxes, a
//               registered pending-write stage and read bypass from it.
// Revision    : 1.0 - initial release
// ============================================================================
import regfile_wb_pipe_pkg::*;

module regfile_wb_pipe #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned SYS_RA   = SYS_RA_DEFAULT,
    parameter int unsigned SYS_RB   = SYS_RB_DEFAULT,
    parameter int unsigned PC_INC   = 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_we,
    input  logic              in_stall,
    input  logic [1:0]        in_wsrc,
    input  logic [1:0]        in_wdst,
    input  logic [DATA_W-1:0] in_Memdata,
    input  logic [DATA_W-1:0] in_R,
    input  logic [DATA_W-1:0] in_pcout,
    input  logic [ADDR_W-1:0] in_p2,
    input  logic [ADDR_W-1:0] in_p4,
    input  logic [ADDR_W-1:0] in_ra,
    input  logic [ADDR_W-1:0] in_rb,
    input  logic              in_syscall,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B,
    output logic              out_pend_valid,
    output logic [ADDR_W-1:0] out_pend_addr
);

    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_dest;
    logic              w_capture;

    logic              r_pend_valid_q, w_pend_valid_d;
    logic [ADDR_W-1:0] r_pend_addr_q,  w_pend_addr_d;
    logic [DATA_W-1:0] r_pend_data_q,  w_pend_data_d;

    logic [ADDR_W-1:0] w_addr_a, w_addr_b;
    logic [DATA_W-1:0] w_arr_a,  w_arr_b;

    always_comb begin
        w_wdata = in_Memdata;
        unique case (in_wsrc)
            WSRC_ALU: w_wdata = in_R;
            WSRC_PC:  w_wdata = in_pcout + DATA_W'(PC_INC);
            default:  w_wdata = in_Memdata;
        endcase
    end

    always_comb begin
        w_dest = ADDR_W'(LINK_REG);
        unique case (in_wdst)
            WDST_P2: w_dest = in_p2;
            WDST_P4: w_dest = in_p4;
            default: w_dest = ADDR_W'(LINK_REG);
        endcase
    end

    // Writes aimed at the hard-wired zero register never enter the pending stage.
    assign w_capture = in_we && !in_stall && !((ZERO_REG != 0) && (w_dest == '0));

    always_comb begin
        w_pend_valid_d = w_capture;
        w_pend_addr_d  = r_pend_addr_q;
        w_pend_data_d  = r_pend_data_q;
        if (w_capture) begin
            w_pend_addr_d = w_dest;
            w_pend_data_d = w_wdata;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_pend_valid_q <= 1'b0;
            r_pend_addr_q  <= '0;
            r_pend_data_q  <= '0;
        end else begin
            r_pend_valid_q <= w_pend_valid_d;
            r_pend_addr_q  <= w_pend_addr_d;
            r_pend_data_q  <= w_pend_data_d;
        end
    end

    regfile_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_array (
        .clk       (in_clk),
        .rst       (in_rst),
        .i_we      (r_pend_valid_q),
        .i_waddr   (r_pend_addr_q),
        .i_wdata   (r_pend_data_q),
        .i_raddr_a (w_addr_a),
        .i_raddr_b (w_addr_b),
        .o_rdata_a (w_arr_a),
        .o_rdata_b (w_arr_b)
    );

    assign w_addr_a = in_syscall ? ADDR_W'(SYS_RA) : in_ra;
    assign w_addr_b = in_syscall ? ADDR_W'(SYS_RB) : in_rb;

    // Bypass covers the one cycle between capture and commit.
    always_comb begin
        out_A = w_arr_a;
        if ((ZERO_REG != 0) && (w_addr_a == '0)) begin
            out_A = '0;
        end else if (r_pend_valid_q && (r_pend_addr_q == w_addr_a)) begin
            out_A = r_pend_data_q;
        end
    end

    always_comb begin
        out_B = w_arr_b;
        if ((ZERO_REG != 0) && (w_addr_b == '0)) begin
            out_B = '0;
        end else if (r_pend_valid_q && (r_pend_addr_q == w_addr_b)) begin
            out_B = r_pend_data_q;
        end
    end

    assign out_pend_valid = r_pend_valid_q;
    assign out_pend_addr  = r_pend_addr_q;

endmodule : regfile_wb_pipe
`default_nettype wire

// File: tb/tb_regfile_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_pipe
// Description : Self-checking bench for regfile_wb_pipe (ZERO_REG=1 and =0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_pipe;

    logic        in_clk = 1'b0;
    logic        in_rst, in_we, in_stall, in_syscall;
    logic [1:0]  in_wsrc, in_wdst;
    logic [31:0] in_Memdata, in_R, in_pcout;
    logic [4:0]  in_p2, in_p4, in_ra, in_rb;

    logic [31:0] a_z, b_z, a_n, b_n;
    logic        pv_z, pv_n;
    logic [4:0]  pa_z, pa_n;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Architectural model: an accepted write is visible to readers from the
    // edge that accepts it; pending status is "accepted on the last edge".
    logic [31:0] ref_z [32];
    logic [31:0] ref_n [32];
    logic        mpv_z, mpv_n;
    logic [4:0]  mpa_z, mpa_n;

    always #5 in_clk = ~in_clk;

    regfile_wb_pipe dut_z (
        .in_clk(in_clk), .in_rst(in_rst), .in_we(in_we), .in_stall(in_stall),
        .in_wsrc(in_wsrc), .in_wdst(in_wdst), .in_Memdata(in_Memdata), .in_R(in_R),
        .in_pcout(in_pcout), .in_p2(in_p2), .in_p4(in_p4), .in_ra(in_ra), .in_rb(in_rb),
        .in_syscall(in_syscall), .out_A(a_z), .out_B(b_z),
        .out_pend_valid(pv_z), .out_pend_addr(pa_z)
    );

    regfile_wb_pipe #(.ZERO_REG(0)) dut_n (
        .in_clk(in_clk), .in_rst(in_rst), .in_we(in_we), .in_stall(in_stall),
        .in_wsrc(in_wsrc), .in_wdst(in_wdst), .in_Memdata(in_Memdata), .in_R(in_R),
        .in_pcout(in_pcout), .in_p2(in_p2), .in_p4(in_p4), .in_ra(in_ra), .in_rb(in_rb),
        .in_syscall(in_syscall), .out_A(a_n), .out_B(b_n),
        .out_pend_valid(pv_n), .out_pend_addr(pa_n)
    );

    function automatic logic [4:0] f_dest();
        if (in_wdst == 2'b00) return in_p2;
        if (in_wdst == 2'b01) return in_p4;
        return 5'd31;
    endfunction

    function automatic logic [31:0] f_wdata();
        if (in_wsrc == 2'b01) return in_R;
        if (in_wsrc == 2'b11) return in_pcout + 32'd1;
        return in_Memdata;
    endfunction

    function automatic logic [4:0] f_ea();
        return in_syscall ? 5'd2 : in_ra;
    endfunction

    function automatic logic [4:0] f_eb();
        return in_syscall ? 5'd4 : in_rb;
    endfunction

    always @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < 32; i++) begin
                ref_z[i] <= '0;
                ref_n[i] <= '0;
            end
            mpv_z <= 1'b0; mpv_n <= 1'b0;
            mpa_z <= '0;   mpa_n <= '0;
        end else begin
            mpv_z <= in_we && !in_stall && (f_dest() != 5'd0);
            mpv_n <= in_we && !in_stall;
            if (in_we && !in_stall && (f_dest() != 5'd0)) begin
                ref_z[f_dest()] <= f_wdata();
                mpa_z           <= f_dest();
            end
            if (in_we && !in_stall) begin
                ref_n[f_dest()] <= f_wdata();
                mpa_n           <= f_dest();
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge in_clk) begin
        if (chk_en && !in_rst) begin
            cmp("model_A_z",  a_z, (f_ea() == 5'd0) ? 32'd0 : ref_z[f_ea()]);
            cmp("model_B_z",  b_z, (f_eb() == 5'd0) ? 32'd0 : ref_z[f_eb()]);
            cmp("model_pv_z", {31'd0, pv_z}, {31'd0, mpv_z});
            if (mpv_z) cmp("model_pa_z", {27'd0, pa_z}, {27'd0, mpa_z});
            cmp("model_A_n",  a_n, ref_n[f_ea()]);
            cmp("model_B_n",  b_n, ref_n[f_eb()]);
            cmp("model_pv_n", {31'd0, pv_n}, {31'd0, mpv_n});
            if (mpv_n) cmp("model_pa_n", {27'd0, pa_n}, {27'd0, mpa_n});
        end
    end

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] src, input logic [1:0] dst, input logic [31:0] val,
                      input logic [4:0] dest);
        in_we = 1'b1; in_wsrc = src; in_wdst = dst;
        in_R = val; in_Memdata = val; in_pcout = val;
        in_p2 = dest; in_p4 = dest;
    endtask

    initial begin
        in_rst = 1'b1; in_we = 1'b0; in_stall = 1'b0; in_syscall = 1'b0;
        in_wsrc = 2'b00; in_wdst = 2'b00; in_Memdata = '0; in_R = '0; in_pcout = '0;
        in_p2 = '0; in_p4 = '0; in_ra = '0; in_rb = '0;
        step(); step();
        in_rst = 1'b0; chk_en = 1'b1;

        // Reset state
        in_ra = 5'd5; in_rb = 5'd31;
        @(negedge in_clk);
        cmp("rst_A", a_z, 32'h0);
        cmp("rst_B", b_z, 32'h0);
        cmp("rst_pv", {31'd0, pv_z}, 32'd0);

        // ALU write to p4=7, bypass then array
        wr(2'b01, 2'b01, 32'hDEADBEEF, 5'd7); in_p2 = 5'd9; in_ra = 5'd7;
        step(); in_we = 1'b0;
        @(negedge in_clk);
        cmp("byp_A", a_z, 32'hDEADBEEF);
        cmp("byp_pv", {31'd0, pv_z}, 32'd1);
        cmp("byp_pa", {27'd0, pa_z}, 32'd7);
        step();
        @(negedge in_clk);
        cmp("arr_A", a_z, 32'hDEADBEEF);
        cmp("arr_pv", {31'd0, pv_z}, 32'd0);

        // Link writes: ALU to link, then PC wrap, then PC+1
        in_ra = 5'd31;
        wr(2'b01, 2'b10, 32'h55, 5'd3); step();
        wr(2'b11, 2'b10, 32'hFFFFFFFF, 5'd3); step(); in_we = 1'b0;
        @(negedge in_clk);
        cmp("link_wrap", a_z, 32'h0);
        cmp("link_pa", {27'd0, pa_z}, 32'd31);
        wr(2'b11, 2'b11, 32'h100, 5'd3); step(); in_we = 1'b0; step();
        @(negedge in_clk);
        cmp("link_101", a_z, 32'h101);

        // Zero register handling
        wr(2'b01, 2'b00, 32'h1234, 5'd0); in_ra = 5'd0; step(); in_we = 1'b0;
        @(negedge in_clk);
        cmp("zero_pv", {31'd0, pv_z}, 32'd0);
        cmp("zero_A", a_z, 32'h0);
        cmp("nz_pv", {31'd0, pv_n}, 32'd1);
        step();
        @(negedge in_clk);
        cmp("nz_A", a_n, 32'h1234);

        // Back-to-back same address, then stalled request
        in_ra = 5'd3;
        wr(2'b01, 2'b00, 32'h11, 5'd3); step();
        wr(2'b01, 2'b00, 32'h22, 5'd3); step();
        @(negedge in_clk);
        cmp("b2b_A", a_z, 32'h22);
        wr(2'b01, 2'b00, 32'h33, 5'd3); in_stall = 1'b1; step();
        @(negedge in_clk);
        cmp("stall_pv", {31'd0, pv_z}, 32'd0);
        cmp("stall_A", a_z, 32'h22);
        in_stall = 1'b0; in_we = 1'b0; step();
        @(negedge in_clk);
        cmp("stall_A2", a_z, 32'h22);

        // Preload r2 (wsrc=10 is memory) and r4, syscall read, reset over pending write
        wr(2'b10, 2'b00, 32'hA, 5'd2); in_pcout = 32'h0; in_R = 32'h0; step();
        wr(2'b00, 2'b01, 32'hB, 5'd4); in_R = 32'h0; step(); in_we = 1'b0;
        in_syscall = 1'b1; in_ra = 5'd9; in_rb = 5'd10;
        step();
        @(negedge in_clk);
        cmp("sys_A", a_z, 32'hA);
        cmp("sys_B", b_z, 32'hB);
        wr(2'b01, 2'b00, 32'h77, 5'd2); step(); in_we = 1'b0;
        @(negedge in_clk);
        cmp("pend_r2", a_z, 32'h77);
        #1 in_rst = 1'b1;
        step(); in_rst = 1'b0;
        @(negedge in_clk);
        cmp("rst_r2", a_z, 32'h0);
        cmp("rst_r4", b_z, 32'h0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_wb_pipe
`default_nettype wire

// File: doc/regfile_wb_pipe.md
Name: regfile_wb_pipe

Overview:
- Parametrised register file with a registered write-back stage and read bypass.
- Selects the write data from three sources: memory data, ALU result, or PC+PC_INC.
- Selects the destination from three sources: p2 field, p4 field, or the link register.
- Syscall forces the read addresses to fixed registers. Sits between the datapath write-back mux and the operand-read stage; also exports pending-write status for the hazard unit.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
LINK_REG, 31, destination index when the link destination is selected
SYS_RA, 2, read-port A address forced during syscall
SYS_RB, 4, read-port B address forced during syscall
PC_INC, 1, increment added to in_pcout for link write data

Ports:
in_clk  input  1  clock, rising edge
in_rst  input  1  synchronous active-high reset
in_we  input  1  write-back request this cycle
in_stall  input  1  blocks capture of a new write-back
in_wsrc  input  2  write data select: 00 mem, 01 ALU, 11 PC+PC_INC, 10 mem
in_wdst  input  2  write dest select: 00 p2, 01 p4, 1x LINK_REG
in_Memdata  input  DATA_W  memory load data
in_R  input  DATA_W  ALU result
in_pcout  input  DATA_W  current PC
in_p2  input  ADDR_W  destination field A
in_p4  input  ADDR_W  destination field B
in_ra  input  ADDR_W  read address A
in_rb  input  ADDR_W  read address B
in_syscall  input  1  force read addresses to SYS_RA/SYS_RB
out_A  output  DATA_W  read data A
out_B  output  DATA_W  read data B
out_pend_valid  output  1  write-back stage holds an uncommitted write
out_pend_addr  output  ADDR_W  destination of the pending write

Behaviour:
- Write-back mux and destination mux are combinational.
- PC+PC_INC addition wraps modulo 2**DATA_W.
- Capture, edge N: if in_we and not in_stall and the computed destination is not (ZERO_REG and 0):
  - pend_valid <= 1
  - pend_addr <= dest
  - pend_data <= wdata
  - otherwise pend_valid <= 0.
- Commit, edge N+1: if pend_valid, array[pend_addr] <= pend_data. Latency from request to array update is 2 edges.
- Back-to-back writes, one per cycle:
  - commit of the old pending entry and capture of the new one happen on the same edge.
  - Same-address back-to-back: the later write wins.
- Stall: no capture; an existing pending entry still commits and pend_valid falls to 0.
- Read ports are combinational:
  - addrA = in_syscall ? SYS_RA : in_ra; likewise B with SYS_RB.
  - If ZERO_REG and addr == 0, output 0.
  - Else if pend_valid and pend_addr == addr, output pend_data (bypass).
  - Else output array[addr].
- No bypass from the current-cycle in_we; the hazard unit uses out_pend_* plus its own same-cycle compare.
- Reset:
  - all array entries <= 0, pend_valid <= 0, pend_addr <= 0, pend_data <= 0.
  - out_A/out_B read 0 the cycle after reset.
  - Reset dominates capture and commit on the same edge; a pending write is discarded.
- in_wsrc = 10 is defined as memory data (not X).

Decomposition:
- Shared package: wsrc codes (WSRC_MEM, WSRC_ALU, WSRC_PC), wdst codes (WDST_P2, WDST_P4, WDST_LINK), default SYS_RA/SYS_RB constants.
- One sub-module: regfile_array — 2-read/1-write storage with synchronous clear and ZERO_REG handling.
- Muxes, the pending stage and the bypass stay in the top module.

Test Plan:
- Reset, then read ra=5, rb=31 -> out_A=0, out_B=0, out_pend_valid=0.
- Write wsrc=ALU, R=0xDEADBEEF, wdst=p4, p4=7, then ra=7:
  - next cycle out_A=0xDEADBEEF via bypass (pend_valid=1, pend_addr=7).
  - the cycle after, same value from the array with pend_valid=0.
- Link write with wsrc=PC, wdst=link, pcout=0xFFFFFFFF -> r31 = 0x00000000 (wrap). Then pcout=0x100 -> r31 = 0x101.
- Write p2=0 with R=0x1234, ZERO_REG=1 -> pend_valid stays 0 and reading r0 gives 0. With ZERO_REG=0 -> r0 = 0x1234.
- Back-to-back writes r3=0x11 then r3=0x22; stall asserted with we=1 the next cycle -> r3 = 0x22 and no third write captured.
- Preload r2=0xA, r4=0xB. Syscall=1 with ra=9, rb=10 -> out_A=0xA, out_B=0xB. Assert in_rst while a write to r2 is pending -> r2 = 0 afterwards.
